control_unit_ws: RTL and testbench
==================================

CONTROL_UNIT_WS -- requirements
Module: control_unit_ws

Interface
REQ-001 Parameter OPW, default 4: opcode width. 3 gives the legacy 8-op set; 4 adds the extended ops.
REQ-002 Parameter WAIT_MAX, default 15, legal range 1..255: consecutive no-ack memory cycles before the block faults.
REQ-003 Clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Enter  in  1  operator input strobe (level).
REQ-006 IR  in  OPW  opcode field, held stable by the external IR register.
REQ-007 Aeq0 / Apos  in  1 each  accumulator zero / positive flags.
REQ-008 MemAck  in  1  memory completion; valid only while MemReq=1.
REQ-009 MemReq  out  1  memory request, held until MemAck.
REQ-010 Meminst  out  1  address select: 0=PC, 1=IR operand.
REQ-011 MemWr  out  1  write qualifier for MemReq.
REQ-012 IRload, PCload, JMPmux, Aload  out  1 each  datapath load/select strobes.
REQ-013 Asel  out  2  accumulator source: 00=ALU, 01=input, 10=memory.
REQ-014 AluOp  out  2  00=add, 01=sub, 10=and, 11=or.
REQ-015 Halt, Fault  out  1 each  halted; halted due to error.
REQ-016 state, next_state  out  4 each  debug view of the FSM.

Function
REQ-017 Encoding: START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ALU=5, INPUT=6, INREL=7, JUMP=8, HALT=9, FAULT=10. Codes 11-15 are unreachable and SHALL go to FAULT.
REQ-018 Outputs are Moore/Mealy on the current state and inputs; any output not named for a state is 0.
REQ-019 START: goes to FETCH on the next cycle.
REQ-020 FETCH: MemReq=1, Meminst=0. On MemAck: IRload=1 and PCload=1 in that same cycle, then DECODE. Otherwise stay in FETCH.
REQ-021 DECODE: one cycle, Meminst=1, then branch on IR:
- 000 -> LOAD; 001 -> STORE; 010 (add) and 011 (sub) -> ALU; 100 -> INPUT; 101 (JZ) and 110 (JPOS) -> JUMP; 111 -> HALT.
- Only IR[2:0] is decoded when OPW=3.
REQ-022 OPW=4 decode: 0xxx decodes as in REQ-021. 1000 (and) and 1001 (or) -> ALU; 1010 (JMP) -> JUMP; 1011-1111 -> FAULT.
REQ-023 LOAD: MemReq=1, Meminst=1. On MemAck: Aload=1, Asel=10, then FETCH.
REQ-024 STORE: MemReq=1, Meminst=1, MemWr=1. On MemAck, go to FETCH.
REQ-025 ALU: MemReq=1, Meminst=1, AluOp from opcode. On MemAck: Aload=1, Asel=00, then FETCH.
REQ-026 INPUT: wait for Enter=1; in that cycle Aload=1, Asel=01, then INREL.
REQ-027 INREL: stay while Enter=1; go to FETCH on the first cycle with Enter=0, so one press loads exactly once.
REQ-028 JUMP, single cycle:
- JMPmux=1 and PCload=1 when (JZ and Aeq0), (JPOS and Apos), or JMP.
- Otherwise no strobes.
- Then FETCH.
REQ-029 HALT: Halt=1; remain until Reset. Enter and MemAck are ignored.
REQ-030 FAULT: Halt=1, Fault=1; remain until Reset.
REQ-031 Wait counter: counts consecutive cycles with MemReq=1 and MemAck=0.
- Cleared on MemAck or on any state change.
- A count of WAIT_MAX moves the FSM to FAULT on the next edge, with no strobes in that cycle.
REQ-032 MemAck in the same cycle the count reaches WAIT_MAX: the ack wins and the normal transition occurs.
REQ-033 MemAck outside a MemReq state is ignored.

Reset
REQ-034 Reset=1 at a rising edge forces state=START and clears the wait counter, overriding every other input, including mid-handshake and in HALT/FAULT.
REQ-035 While in START: all outputs 0 and next_state=FETCH.

Structure
REQ-036 State codes, opcode constants and Asel/AluOp encodings live in the shared package cu_pkg.
REQ-037 The wait counter is the sub-module mem_wait_timer: Clock, Reset, clr, req, ack -> expired.
REQ-038 The FSM uses a two-process style with registered state only; next_state is combinational.

Verification
REQ-039 Reset pulse, then MemAck tied 1 with IR=000: expect START -> FETCH (IRload=1, PCload=1) -> DECODE -> LOAD (Aload=1, Asel=10) -> FETCH.
REQ-040 IR=0101 (JZ), Aeq0=0 then Aeq0=1: the first pass has JMPmux=PCload=0 in JUMP; the second has both =1.
REQ-041 IR=100, Enter held 1 for 5 cycles then 0: Aload pulses exactly once; INREL is held 4 cycles, then FETCH.
REQ-042 WAIT_MAX=3, MemAck=0 in FETCH: FAULT on the 4th edge with Fault=Halt=1. Repeat with MemAck=1 on the 3rd cycle: no fault.
REQ-043 OPW=4, IR=1100: DECODE -> FAULT. Then OPW=3, IR=111: HALT, and Halt holds for 50 cycles with Enter toggling.
REQ-044 Reset asserted during a STORE wait: state=START on the next edge, with MemReq=MemWr=0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared constants for the accumulator-machine control unit: state codes,
// opcodes, datapath select encodings and the decode helpers.
package cu_pkg;

  localparam logic [3:0] S_START  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_STORE  = 4'd4;
  localparam logic [3:0] S_ALU    = 4'd5;
  localparam logic [3:0] S_INPUT  = 4'd6;
  localparam logic [3:0] S_INREL  = 4'd7;
  localparam logic [3:0] S_JUMP   = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;
  localparam logic [3:0] S_FAULT  = 4'd10;

  // Opcodes are carried zero-extended to 4 bits, so the legacy 3-bit set
  // never reaches the extended codes.
  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_INPUT = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;
  localparam logic [3:0] OP_JPOS  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_AND   = 4'h8;
  localparam logic [3:0] OP_OR    = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  localparam int unsigned WAIT_CNT_W = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_inst;
    logic       mem_wr;
    logic       ir_load;
    logic       pc_load;
    logic       jmp_mux;
    logic       a_load;
    logic [1:0] a_sel;
    logic [1:0] alu_op;
    logic       halt;
    logic       fault;
  } cu_ctrl_t;

  localparam cu_ctrl_t CTRL_IDLE = '0;

  function automatic logic [3:0] decode_target(input logic [3:0] op);
    logic [3:0] tgt;
    tgt = S_FAULT;
    case (op)
      OP_LOAD:                         tgt = S_LOAD;
      OP_STORE:                        tgt = S_STORE;
      OP_ADD, OP_SUB, OP_AND, OP_OR:   tgt = S_ALU;
      OP_INPUT:                        tgt = S_INPUT;
      OP_JZ, OP_JPOS, OP_JMP:          tgt = S_JUMP;
      OP_HALT:                         tgt = S_HALT;
      default:                         tgt = S_FAULT;
    endcase
    return tgt;
  endfunction

  function automatic logic [1:0] alu_op_of(input logic [3:0] op);
    logic [1:0] aop;
    aop = ALU_ADD;
    case (op)
      OP_SUB:  aop = ALU_SUB;
      OP_AND:  aop = ALU_AND;
      OP_OR:   aop = ALU_OR;
      default: aop = ALU_ADD;
    endcase
    return aop;
  endfunction

  function automatic logic jump_taken(input logic [3:0] op, input logic aeq0,
                                      input logic apos);
    return ((op == OP_JZ) && aeq0) || ((op == OP_JPOS) && apos) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive requested-but-unacknowledged memory cycles and flags
// when the count has reached WAIT_MAX.
module mem_wait_timer
  import cu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  // Saturates at WAIT_MAX; the FSM leaves the waiting state on that cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (req && ack)) begin
      cnt_d = '0;
    end else if (req && (cnt_q != WAIT_CNT_W'(WAIT_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Not gated by req: the FSM only consults it in memory-request states.
  assign expired = (cnt_q == WAIT_CNT_W'(WAIT_MAX));

endmodule

// File: rtl/control_unit_ws.sv
// Control FSM for a small accumulator machine with memory handshake,
// wait-state timeout to FAULT, and optional 4-bit extended opcode set.
module control_unit_ws
  import cu_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Enter,
  input  logic [OPW-1:0] IR,
  input  logic           Aeq0,
  input  logic           Apos,
  input  logic           MemAck,
  output logic           MemReq,
  output logic           Meminst,
  output logic           MemWr,
  output logic           IRload,
  output logic           PCload,
  output logic           JMPmux,
  output logic           Aload,
  output logic [1:0]     Asel,
  output logic [1:0]     AluOp,
  output logic           Halt,
  output logic           Fault,
  output logic [3:0]     state,
  output logic [3:0]     next_state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] op;
  cu_ctrl_t   ctrl;
  logic       expired;
  logic       timer_clr;

  assign op = 4'(IR);

  // NOTE: every output and next-state gets a default before the case so no path infers a latch.
  always_comb begin
    ctrl    = CTRL_IDLE;
    state_d = state_q;
    case (state_q)
      S_START: state_d = S_FETCH;

      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (MemAck) begin
          ctrl.ir_load = 1'b1;
          ctrl.pc_load = 1'b1;
          state_d      = S_DECODE;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        ctrl.mem_inst = 1'b1;
        state_d       = decode_target(op);
      end

      S_LOAD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_inst = 1'b1;
        if (MemAck) begin
          ctrl.a_load = 1'b1;
          ctrl.a_sel  = ASEL_MEM;
          state_d     = S_FETCH;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end

      S_STORE: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_inst = 1'b1;
        ctrl.mem_wr   = 1'b1;
        if (MemAck) begin
          state_d = S_FETCH;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end

      S_ALU: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_inst = 1'b1;
        ctrl.alu_op   = alu_op_of(op);
        if (MemAck) begin
          ctrl.a_load = 1'b1;
          ctrl.a_sel  = ASEL_ALU;
          state_d     = S_FETCH;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end

      S_INPUT: begin
        if (Enter) begin
          ctrl.a_load = 1'b1;
          ctrl.a_sel  = ASEL_IN;
          state_d     = S_INREL;
        end
      end

      // Wait for release so a single press loads the accumulator once.
      S_INREL: begin
        if (!Enter) begin
          state_d = S_FETCH;
        end
      end

      S_JUMP: begin
        if (jump_taken(op, Aeq0, Apos)) begin
          ctrl.jmp_mux = 1'b1;
          ctrl.pc_load = 1'b1;
        end
        state_d = S_FETCH;
      end

      S_HALT: ctrl.halt = 1'b1;

      S_FAULT: begin
        ctrl.halt  = 1'b1;
        ctrl.fault = 1'b1;
      end

      default: state_d = S_FAULT;
    endcase
  end

  // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  assign timer_clr = (state_d != state_q);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait (
    .Clock   (Clock),
    .Reset   (Reset),
    .clr     (timer_clr),
    .req     (ctrl.mem_req),
    .ack     (MemAck),
    .expired (expired)
  );

  assign MemReq     = ctrl.mem_req;
  assign Meminst    = ctrl.mem_inst;
  assign MemWr      = ctrl.mem_wr;
  assign IRload     = ctrl.ir_load;
  assign PCload     = ctrl.pc_load;
  assign JMPmux     = ctrl.jmp_mux;
  assign Aload      = ctrl.a_load;
  assign Asel       = ctrl.a_sel;
  assign AluOp      = ctrl.alu_op;
  assign Halt       = ctrl.halt;
  assign Fault      = ctrl.fault;
  assign state      = state_q;
  assign next_state = state_d;

endmodule

// File: tb/tb_control_unit_ws.sv
// Bench for control_unit_ws: three configurations (OPW=4/WAIT_MAX=15,
// OPW=4/WAIT_MAX=3, OPW=3/WAIT_MAX=15) sharing one stimulus.
module tb_control_unit_ws;

  localparam int START = 0, FETCH = 1, DECODE = 2, LOAD = 3, STORE = 4, ALU = 5,
                 INPUT = 6, INREL = 7, JUMP = 8, HALT = 9, FAULT = 10;
  localparam int WMAX_W = 3;

  logic       Clock = 1'b0;
  logic       Reset, Enter, Aeq0, Apos, MemAck;
  logic [3:0] ir;

  logic       memreq[3], meminst[3], memwr[3], irload[3], pcload[3];
  logic       jmpmux[3], aload[3], halt[3], fault[3];
  logic [1:0] asel[3], aluop[3];
  logic [3:0] st[3], nst[3];

  int n_checks = 0;
  int n_fail   = 0;

  int dec_tab[16];
  int alu_tab[16];

  always #5 Clock = ~Clock;

  control_unit_ws #(.OPW(4), .WAIT_MAX(15)) dut (
    .Clock(Clock), .Reset(Reset), .Enter(Enter), .IR(ir), .Aeq0(Aeq0), .Apos(Apos),
    .MemAck(MemAck), .MemReq(memreq[0]), .Meminst(meminst[0]), .MemWr(memwr[0]),
    .IRload(irload[0]), .PCload(pcload[0]), .JMPmux(jmpmux[0]), .Aload(aload[0]),
    .Asel(asel[0]), .AluOp(aluop[0]), .Halt(halt[0]), .Fault(fault[0]),
    .state(st[0]), .next_state(nst[0]));

  control_unit_ws #(.OPW(4), .WAIT_MAX(WMAX_W)) dut_w3 (
    .Clock(Clock), .Reset(Reset), .Enter(Enter), .IR(ir), .Aeq0(Aeq0), .Apos(Apos),
    .MemAck(MemAck), .MemReq(memreq[1]), .Meminst(meminst[1]), .MemWr(memwr[1]),
    .IRload(irload[1]), .PCload(pcload[1]), .JMPmux(jmpmux[1]), .Aload(aload[1]),
    .Asel(asel[1]), .AluOp(aluop[1]), .Halt(halt[1]), .Fault(fault[1]),
    .state(st[1]), .next_state(nst[1]));

  control_unit_ws #(.OPW(3), .WAIT_MAX(15)) dut_o3 (
    .Clock(Clock), .Reset(Reset), .Enter(Enter), .IR(ir[2:0]), .Aeq0(Aeq0), .Apos(Apos),
    .MemAck(MemAck), .MemReq(memreq[2]), .Meminst(meminst[2]), .MemWr(memwr[2]),
    .IRload(irload[2]), .PCload(pcload[2]), .JMPmux(jmpmux[2]), .Aload(aload[2]),
    .Asel(asel[2]), .AluOp(aluop[2]), .Halt(halt[2]), .Fault(fault[2]),
    .state(st[2]), .next_state(nst[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [12:0] get_obs(input int k);
    return {memreq[k], meminst[k], memwr[k], irload[k], pcload[k], jmpmux[k], aload[k],
            asel[k], aluop[k], halt[k], fault[k]};
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic run_to(input int k, input int target, input int budget);
    int n = 0;
    while ((int'(st[k]) != target) && (n < budget)) begin
      tick();
      n++;
    end
    check($sformatf("run_to_%0d_dut%0d", target, k), st[k], target);
  endtask

  // Reference behaviour for one cycle, from the current state, wait count and inputs.
  task automatic model_eval(input int s, input int w, output logic [12:0] o, output int nxt);
    logic req, inst, wr, irl, pcl, jmp, ald, hlt, flt;
    logic [1:0] as, ao;
    bit mem_state, taken;
    mem_state = (s == FETCH) || (s == LOAD) || (s == STORE) || (s == ALU);
    req = mem_state; inst = mem_state && (s != FETCH); wr = (s == STORE);
    irl = 0; pcl = 0; jmp = 0; ald = 0; hlt = 0; flt = 0; as = 2'd0; ao = 2'd0;
    nxt = s;
    if (mem_state && MemAck) begin
      nxt = (s == FETCH) ? DECODE : FETCH;
      irl = (s == FETCH);
      pcl = (s == FETCH);
      ald = (s == LOAD) || (s == ALU);
      as  = (s == LOAD) ? 2'd2 : 2'd0;
    end else if (mem_state && (w >= WMAX_W)) begin
      nxt = FAULT;
    end
    if (s == ALU) ao = 2'(alu_tab[ir]);
    taken = ((ir == 4'h5) && Aeq0) || ((ir == 4'h6) && Apos) || (ir == 4'hA);
    case (s)
      START:  nxt = FETCH;
      DECODE: begin inst = 1; nxt = dec_tab[ir]; end
      INPUT:  if (Enter) begin ald = 1; as = 2'd1; nxt = INREL; end
      INREL:  if (!Enter) nxt = FETCH;
      JUMP:   begin if (taken) begin jmp = 1; pcl = 1; end nxt = FETCH; end
      HALT:   hlt = 1;
      FAULT:  begin hlt = 1; flt = 1; end
      default: ;
    endcase
    o = {req, inst, wr, irl, pcl, jmp, ald, as, ao, hlt, flt};
  endtask

  typedef struct {
    int         k;
    logic [3:0] ir;
    int         exp_next;
    int         exp_alu;
  } dec_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t   vecs[$];
    int         aload_cnt, inrel_cnt, m_st, m_wait, e_nxt;
    logic [12:0] e_obs;

    dec_tab = '{LOAD, STORE, ALU, ALU, INPUT, JUMP, JUMP, HALT,
                ALU, ALU, JUMP, FAULT, FAULT, FAULT, FAULT, FAULT};
    alu_tab = '{0, 0, 0, 1, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0};

    Reset = 1'b1; Enter = 0; Aeq0 = 0; Apos = 0; MemAck = 0; ir = 4'h0;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state and the basic LOAD walk
    check("reset_state", st[0], START);
    check("reset_outputs", get_obs(0), 13'h0);
    check("reset_next", nst[0], FETCH);
    MemAck = 1;
    tick();
    check("fetch_state", st[0], FETCH);
    check("fetch_irload_pcload", {irload[0], pcload[0], memreq[0], meminst[0]}, 4'b1110);
    check("fetch_next", nst[0], DECODE);
    tick();
    check("decode_meminst", meminst[0], 1'b1);
    check("decode_next", nst[0], LOAD);
    tick();
    check("load_state", st[0], LOAD);
    check("load_aload_asel", {aload[0], asel[0]}, 3'b110);
    tick();
    check("load_to_fetch", st[0], FETCH);

    // Decode table, both opcode widths
    vecs.push_back('{0, 4'h0, LOAD, -1});  vecs.push_back('{0, 4'h1, STORE, -1});
    vecs.push_back('{0, 4'h2, ALU, 0});    vecs.push_back('{0, 4'h3, ALU, 1});
    vecs.push_back('{0, 4'h4, INPUT, -1}); vecs.push_back('{0, 4'h5, JUMP, -1});
    vecs.push_back('{0, 4'h6, JUMP, -1});  vecs.push_back('{0, 4'h7, HALT, -1});
    vecs.push_back('{0, 4'h8, ALU, 2});    vecs.push_back('{0, 4'h9, ALU, 3});
    vecs.push_back('{0, 4'hA, JUMP, -1});  vecs.push_back('{0, 4'hB, FAULT, -1});
    vecs.push_back('{0, 4'hC, FAULT, -1}); vecs.push_back('{0, 4'hF, FAULT, -1});
    vecs.push_back('{2, 4'hB, ALU, 1});    vecs.push_back('{2, 4'hF, HALT, -1});
    vecs.push_back('{2, 4'hC, INPUT, -1}); vecs.push_back('{2, 4'h8, LOAD, -1});
    vecs.push_back('{2, 4'h9, STORE, -1}); vecs.push_back('{2, 4'hE, JUMP, -1});
    foreach (vecs[i]) begin
      ir = vecs[i].ir; MemAck = 1; Enter = 0;
      do_reset();
      run_to(vecs[i].k, DECODE, 8);
      check($sformatf("dec_next_ir%0h_dut%0d", vecs[i].ir, vecs[i].k), nst[vecs[i].k], vecs[i].exp_next);
      if (vecs[i].exp_alu >= 0) begin
        tick();
        check($sformatf("dec_aluop_ir%0h_dut%0d", vecs[i].ir, vecs[i].k), aluop[vecs[i].k], vecs[i].exp_alu);
      end
    end

    // JZ not taken then taken
    ir = 4'h5; MemAck = 1; Aeq0 = 0;
    do_reset();
    run_to(0, JUMP, 8);
    check("jz_not_taken", {jmpmux[0], pcload[0]}, 2'b00);
    tick();
    run_to(0, JUMP, 8);
    Aeq0 = 1;
    #1;
    check("jz_taken", {jmpmux[0], pcload[0]}, 2'b11);
    check("jump_next", nst[0], FETCH);
    Aeq0 = 0;

    // One Enter press held 5 cycles loads once
    ir = 4'h4; MemAck = 1; Enter = 0;
    do_reset();
    run_to(0, INPUT, 8);
    tick();
    check("input_waits", st[0], INPUT);
    aload_cnt = 0; inrel_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      Enter = 1;
      #1;
      aload_cnt += int'(aload[0]);
      if (int'(st[0]) == INREL) inrel_cnt++;
      tick();
    end
    Enter = 0;
    #1;
    check("input_aload_once", aload_cnt, 1);
    check("inrel_held_cycles", inrel_cnt, 4);
    check("inrel_release_next", nst[0], FETCH);
    tick();
    check("inrel_to_fetch", st[0], FETCH);

    // Wait timeout with WAIT_MAX=3
    ir = 4'h0; MemAck = 0;
    do_reset();
    tick();
    check("to_fetch_entered", st[1], FETCH);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("to_fetch_edge%0d", e), st[1], FETCH);
    end
    check("to_expire_next", nst[1], FAULT);
    check("to_expire_no_strobe", {irload[1], pcload[1], aload[1]}, 3'b000);
    tick();
    check("to_fault_state", st[1], FAULT);
    check("to_fault_flags", {halt[1], fault[1]}, 2'b11);

    // Ack on the 3rd FETCH cycle
    do_reset();
    tick();
    tick();
    tick();
    MemAck = 1;
    tick();
    check("ack_3rd_no_fault", st[1], DECODE);

    // Ack in the very cycle the count reaches WAIT_MAX
    MemAck = 0;
    do_reset();
    tick();
    tick();
    tick();
    tick();
    MemAck = 1;
    #1;
    check("ack_at_max_next", nst[1], DECODE);
    check("ack_at_max_irload", irload[1], 1'b1);
    tick();
    check("ack_at_max_state", st[1], DECODE);

    // HALT holds with Enter toggling (OPW=3, IR=111)
    ir = 4'h7; MemAck = 1; Enter = 0;
    do_reset();
    run_to(2, HALT, 8);
    for (int c = 0; c < 50; c++) begin
      Enter = ~Enter;
      MemAck = 1'($urandom_range(0, 1));
      #1;
      check("halt_holds", {st[2], halt[2], fault[2]}, {4'(HALT), 2'b10});
      tick();
    end
    Reset = 1; tick(); Reset = 0;
    check("reset_from_halt", st[2], START);

    // Reset in the middle of a STORE wait
    ir = 4'h1; MemAck = 1; Enter = 0;
    do_reset();
    run_to(0, STORE, 8);
    MemAck = 0;
    #1;
    check("store_req_wr", {memreq[0], memwr[0]}, 2'b11);
    tick();
    Reset = 1;
    tick();
    Reset = 0;
    check("store_reset_state", st[0], START);
    check("store_reset_outputs", {memreq[0], memwr[0]}, 2'b00);

    // Randomized run against the reference model (WAIT_MAX=3 instance)
    do_reset();
    m_st = START; m_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      Reset  = ((m_st >= HALT) && ($urandom_range(0, 4) == 0)) || ($urandom_range(0, 99) == 0);
      Enter  = 1'($urandom_range(0, 1));
      Aeq0   = 1'($urandom_range(0, 1));
      Apos   = 1'($urandom_range(0, 1));
      MemAck = ($urandom_range(0, 9) < 6);
      if ((m_st == FETCH) || (m_st == START)) ir = 4'($urandom_range(0, 15));
      #1;
      model_eval(m_st, m_wait, e_obs, e_nxt);
      check("rand_state", st[1], m_st);
      check("rand_outputs", get_obs(1), e_obs);
      check("rand_next", nst[1], e_nxt);
      tick();
      if (Reset) begin
        m_st = START; m_wait = 0;
      end else begin
        if ((m_st == FETCH || m_st == LOAD || m_st == STORE || m_st == ALU) && !MemAck && (e_nxt == m_st))
          m_wait = m_wait + 1;
        else
          m_wait = 0;
        m_st = e_nxt;
      end
    end
    Reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
